// File: rtl/cache_refill.sv
// Cache line refill engine: captures a miss, issues one line read to memory,
// streams the response beats into the data RAM and then installs the tag.
module cache_refill #(
   parameter int unsigned CACHE_SET_ASSOCIATIVITY = 4,
   parameter int unsigned SET_PTR_WIDTH_IN_BITS   = 6,
   parameter int unsigned TAG_WIDTH_IN_BITS       = 22,
   parameter int unsigned WORD_PTR_WIDTH_IN_BITS  = 2
) (
   input  logic                               clk_in,
   input  logic                               reset_n_in,
   input  logic                               miss_valid_in,
   output logic                               miss_ready_out,
   input  logic [SET_PTR_WIDTH_IN_BITS-1:0]   miss_set_addr_in,
   input  logic [TAG_WIDTH_IN_BITS-1:0]       miss_tag_in,
   input  logic [CACHE_SET_ASSOCIATIVITY-1:0] victim_way_in,
   output logic                               mem_req_valid_out,
   input  logic                               mem_req_ready_in,
   output logic [31:0]                        mem_req_addr_out,
   input  logic                               mem_resp_valid_in,
   input  logic [31:0]                        mem_resp_data_in,
   output logic                               line_we_out,
   output logic [CACHE_SET_ASSOCIATIVITY-1:0] line_way_out,
   output logic [SET_PTR_WIDTH_IN_BITS-1:0]   line_set_addr_out,
   output logic [WORD_PTR_WIDTH_IN_BITS-1:0]  line_word_ptr_out,
   output logic [31:0]                        line_data_out,
   output logic                               tag_we_out,
   output logic [TAG_WIDTH_IN_BITS-1:0]       tag_out,
   output logic                               refill_done_out,
   output logic                               busy_out
);

   localparam int unsigned ADDR_W = TAG_WIDTH_IN_BITS + SET_PTR_WIDTH_IN_BITS
                                    + WORD_PTR_WIDTH_IN_BITS + 2;

   typedef enum logic [1:0] {IDLE, REQ, RESP, COMMIT} state_t;

   state_t                               state;
   logic [WORD_PTR_WIDTH_IN_BITS-1:0]    word_cnt;
   logic [SET_PTR_WIDTH_IN_BITS-1:0]     set_q;
   logic [TAG_WIDTH_IN_BITS-1:0]         tag_q;
   logic [CACHE_SET_ASSOCIATIVITY-1:0]   way_q;
   logic [CACHE_SET_ASSOCIATIVITY-1:0]   victim_low;
   logic [ADDR_W-1:0]                    line_addr;

   // Isolate the lowest set bit; an empty victim vector falls back to way 0.
   always_comb begin
      victim_low = victim_way_in & (~victim_way_in + CACHE_SET_ASSOCIATIVITY'(1));
      if (victim_low == '0)
         victim_low = CACHE_SET_ASSOCIATIVITY'(1);
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state    <= IDLE;
         word_cnt <= '0;
         set_q    <= '0;
         tag_q    <= '0;
         way_q    <= '0;
      end else begin
         case (state)
            IDLE: if (miss_valid_in) begin
               set_q <= miss_set_addr_in;
               tag_q <= miss_tag_in;
               way_q <= victim_low;
               state <= REQ;
            end
            REQ: if (mem_req_ready_in) begin
               word_cnt <= '0;
               state    <= RESP;
            end
            RESP: if (mem_resp_valid_in) begin
               word_cnt <= word_cnt + WORD_PTR_WIDTH_IN_BITS'(1);
               if (word_cnt == '1)
                  state <= COMMIT;
            end
            COMMIT: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign line_addr = {tag_q, set_q, {WORD_PTR_WIDTH_IN_BITS{1'b0}}, 2'b00};

   generate
      if (ADDR_W >= 32) begin : g_addr_trunc
         assign mem_req_addr_out = line_addr[31:0];
      end else begin : g_addr_ext
         assign mem_req_addr_out = {{(32 - ADDR_W){1'b0}}, line_addr};
      end
   endgenerate

   always_comb begin
      miss_ready_out    = (state == IDLE);
      busy_out          = (state != IDLE);
      mem_req_valid_out = (state == REQ);
      line_we_out       = (state == RESP) && mem_resp_valid_in;
      line_data_out     = mem_resp_data_in;
      line_word_ptr_out = word_cnt;
      line_way_out      = way_q;
      line_set_addr_out = set_q;
      tag_we_out        = (state == COMMIT);
      refill_done_out   = (state == COMMIT);
      tag_out           = tag_q;
   end

endmodule

// File: tb/tb_cache_refill.sv
// Bench for cache_refill: table of refill scenarios plus hand-built sequences,
// with data RAM writes checked against a scoreboard of driven beats.
module tb_cache_refill;

   logic        clk_in = 1'b0;
   logic        reset_n_in;
   logic        miss_valid_in;
   logic        miss_ready_out;
   logic [5:0]  miss_set_addr_in;
   logic [21:0] miss_tag_in;
   logic [3:0]  victim_way_in;
   logic        mem_req_valid_out;
   logic        mem_req_ready_in;
   logic [31:0] mem_req_addr_out;
   logic        mem_resp_valid_in;
   logic [31:0] mem_resp_data_in;
   logic        line_we_out;
   logic [3:0]  line_way_out;
   logic [5:0]  line_set_addr_out;
   logic [1:0]  line_word_ptr_out;
   logic [31:0] line_data_out;
   logic        tag_we_out;
   logic [21:0] tag_out;
   logic        refill_done_out;
   logic        busy_out;

   cache_refill #(
      .CACHE_SET_ASSOCIATIVITY(4),
      .SET_PTR_WIDTH_IN_BITS(6),
      .TAG_WIDTH_IN_BITS(22),
      .WORD_PTR_WIDTH_IN_BITS(2)
   ) dut (
      .clk_in(clk_in), .reset_n_in(reset_n_in),
      .miss_valid_in(miss_valid_in), .miss_ready_out(miss_ready_out),
      .miss_set_addr_in(miss_set_addr_in), .miss_tag_in(miss_tag_in),
      .victim_way_in(victim_way_in),
      .mem_req_valid_out(mem_req_valid_out), .mem_req_ready_in(mem_req_ready_in),
      .mem_req_addr_out(mem_req_addr_out),
      .mem_resp_valid_in(mem_resp_valid_in), .mem_resp_data_in(mem_resp_data_in),
      .line_we_out(line_we_out), .line_way_out(line_way_out),
      .line_set_addr_out(line_set_addr_out), .line_word_ptr_out(line_word_ptr_out),
      .line_data_out(line_data_out), .tag_we_out(tag_we_out), .tag_out(tag_out),
      .refill_done_out(refill_done_out), .busy_out(busy_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [5:0]  set;
      logic [21:0] tag;
      logic [3:0]  victim;
      logic [3:0]  exp_way;
      logic [31:0] exp_addr;
      int          req_delay;
      bit          gap;
      int          exp_lat;
   } vec_t;

   typedef struct {
      logic [3:0]  way;
      logic [5:0]  set;
      logic [1:0]  ptr;
      logic [31:0] data;
   } wr_t;

   wr_t  sb[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   vec_t vecs[5];

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Every data RAM write must match the oldest outstanding driven beat.
   always @(negedge clk_in) begin
      if (refill_done_out) done_cnt++;
      if (line_we_out === 1'b1) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write: got ptr %0d data 0x%0h, expected no write",
                     line_word_ptr_out, line_data_out);
         end else begin
            wr_t e;
            e = sb.pop_front();
            if (line_way_out !== e.way || line_set_addr_out !== e.set ||
                line_word_ptr_out !== e.ptr || line_data_out !== e.data) begin
               fails++;
               $display("FAIL write: got way %b set %0d ptr %0d data 0x%0h expected way %b set %0d ptr %0d data 0x%0h",
                        line_way_out, line_set_addr_out, line_word_ptr_out, line_data_out,
                        e.way, e.set, e.ptr, e.data);
            end
         end
      end
   end

   task automatic run_refill(input vec_t v, input bit keep_miss, input vec_t nxt);
      int c0, d0;
      logic [31:0] d;
      d0 = done_cnt;
      miss_valid_in    = 1'b1;
      miss_set_addr_in = v.set;
      miss_tag_in      = v.tag;
      victim_way_in    = v.victim;
      c0 = cyc;
      @(negedge clk_in);
      chk("miss_ready_idle", 64'(miss_ready_out), 64'd1);
      @(posedge clk_in); #1;
      miss_valid_in = 1'b0;
      for (int i = 0; i < v.req_delay; i++) begin
         @(negedge clk_in);
         chk("req_addr_stall", 64'(mem_req_addr_out), 64'(v.exp_addr));
         chk("req_valid_stall", 64'({mem_req_valid_out, line_we_out, busy_out}), 64'b101);
         @(posedge clk_in); #1;
      end
      mem_req_ready_in = 1'b1;
      @(negedge clk_in);
      chk("req_addr", 64'(mem_req_addr_out), 64'(v.exp_addr));
      chk("req_valid", 64'(mem_req_valid_out), 64'd1);
      @(posedge clk_in); #1;
      mem_req_ready_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (v.gap && i > 0) begin
            mem_resp_valid_in = 1'b0;
            @(posedge clk_in); #1;
         end
         d = $urandom;
         sb.push_back('{way: v.exp_way, set: v.set, ptr: 2'(i), data: d});
         mem_resp_valid_in = 1'b1;
         mem_resp_data_in  = d;
         if (keep_miss) begin
            miss_valid_in    = 1'b1;
            miss_set_addr_in = nxt.set;
            miss_tag_in      = nxt.tag;
            victim_way_in    = nxt.victim;
         end
         @(negedge clk_in);
         if (keep_miss) chk("miss_ready_busy", 64'(miss_ready_out), 64'd0);
         @(posedge clk_in); #1;
      end
      mem_resp_valid_in = 1'b0;
      @(negedge clk_in);
      chk("commit_strobes", 64'({tag_we_out, refill_done_out, line_we_out, mem_req_valid_out}), 64'b1100);
      chk("commit_tag", 64'(tag_out), 64'(v.tag));
      chk("latency", 64'(cyc - c0 + 1), 64'(v.exp_lat));
      @(posedge clk_in); #1;
      chk("done_pulses", 64'(done_cnt - d0), 64'd1);
      chk("sb_drained", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      vec_t none;
      int   d0;
      vecs[0] = '{6'd5,  22'h001234, 4'b0100, 4'b0100, 32'h0048D050, 0, 1'b0, 7};
      vecs[1] = '{6'd10, 22'h3FFFFF, 4'b0001, 4'b0001, 32'hFFFFFCA0, 3, 1'b0, 10};
      vecs[2] = '{6'd63, 22'h2AAAAA, 4'b1000, 4'b1000, 32'hAAAAABF0, 0, 1'b1, 10};
      vecs[3] = '{6'd0,  22'h000001, 4'b0000, 4'b0001, 32'h00000400, 1, 1'b0, 8};
      vecs[4] = '{6'd33, 22'h155555, 4'b0110, 4'b0010, 32'h55555610, 0, 1'b1, 10};
      none = vecs[0];

      reset_n_in = 1'b0; miss_valid_in = 1'b0; miss_set_addr_in = '0; miss_tag_in = '0;
      victim_way_in = '0; mem_req_ready_in = 1'b0; mem_resp_valid_in = 1'b0;
      mem_resp_data_in = '0;
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      chk("reset_strobes", 64'({miss_ready_out, busy_out, mem_req_valid_out, line_we_out,
                                tag_we_out, refill_done_out}), 64'b100000);
      chk("reset_latched", 64'({line_way_out, line_set_addr_out, tag_out, mem_req_addr_out}), 64'd0);
      @(posedge clk_in); #1;
      reset_n_in = 1'b1;

      // Stray beat while idle must not write.
      mem_resp_valid_in = 1'b1; mem_resp_data_in = 32'hDEADBEEF;
      @(negedge clk_in);
      chk("stray_beat", 64'({line_we_out, busy_out}), 64'd0);
      @(posedge clk_in); #1;
      mem_resp_valid_in = 1'b0;

      foreach (vecs[i]) run_refill(vecs[i], 1'b0, none);

      // Second miss held during RESP is only taken after the first completes.
      run_refill(vecs[1], 1'b1, vecs[4]);
      run_refill(vecs[4], 1'b0, none);

      // Reset after the second beat aborts the refill.
      d0 = done_cnt;
      miss_valid_in = 1'b1; miss_set_addr_in = 6'd9; miss_tag_in = 22'h0ABCDE;
      victim_way_in = 4'b0010;
      @(posedge clk_in); #1;
      miss_valid_in = 1'b0; mem_req_ready_in = 1'b1;
      @(posedge clk_in); #1;
      mem_req_ready_in = 1'b0;
      for (int i = 0; i < 2; i++) begin
         mem_resp_data_in = $urandom;
         sb.push_back('{way: 4'b0010, set: 6'd9, ptr: 2'(i), data: mem_resp_data_in});
         mem_resp_valid_in = 1'b1;
         @(posedge clk_in); #1;
      end
      reset_n_in = 1'b0;
      repeat (2) begin
         @(negedge clk_in);
         chk("abort_strobes", 64'({line_we_out, tag_we_out, refill_done_out, mem_req_valid_out,
                                   busy_out}), 64'd0);
         @(posedge clk_in); #1;
      end
      mem_resp_valid_in = 1'b0;
      reset_n_in = 1'b1;
      @(negedge clk_in);
      chk("abort_ready", 64'({miss_ready_out, busy_out}), 64'b10);
      chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
      chk("abort_sb", 64'(sb.size()), 64'd0);
      @(posedge clk_in); #1;
      run_refill(vecs[2], 1'b0, none);

      repeat (3) @(posedge clk_in);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
